// File: rtl/cgra_mux_pkg.sv
// Shared definitions for the CGRA datapath multiplexers: select-mode
// encoding, channel-count ceiling and the round-robin pointer step.
package cgra_mux_pkg;

   typedef enum logic {
      MUX_MODE_FIXED = 1'b0,
      MUX_MODE_RR    = 1'b1
   } mux_mode_e;

   localparam int N_IN_MAX = 16;

   // Pointer position that follows a granted channel, wrapping to 0 after the last one.
   function automatic int rr_next_ptr(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_mux_n_if.sv
// Handshake bundle between the PE output ports, the N:1 mux and the routing
// fabric. The slave modport is the mux's view; master is the environment's.
interface rr_mux_n_if
   import cgra_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4
);

   localparam int SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      sel;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_src;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_src
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the request vector is rotated so that
// the pointer position sits at bit 0, the lowest set bit is found, and the
// result is rotated back into an absolute channel index.
module rr_arbiter
   import cgra_mux_pkg::*;
#(
   parameter  int N_IN  = 4,
   localparam int SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] grant,
   output logic             grant_valid
);

   logic [N_IN-1:0]  rotated;
   logic [SEL_W-1:0] first;

   // Rotate requests so the channel at ptr becomes bit 0.
   always_comb begin
      rotated = '0;
      for (int i = 0; i < N_IN; i++) begin
         rotated[i] = req[(i + int'(ptr)) % N_IN];
      end
   end

   // Lowest set bit of the rotated vector is the highest-priority requester.
   always_comb begin
      first = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            first = SEL_W'(i);
         end
      end
   end

   // Undo the rotation to get the absolute channel index.
   always_comb begin
      grant = SEL_W'((int'(first) + int'(ptr)) % N_IN);
   end

   assign grant_valid = |req;

endmodule

// File: rtl/rr_mux_n.sv
// Registered N:1 stream multiplexer with valid/ready handshaking. A channel
// is picked either by an explicit index or by round-robin arbitration, and
// the chosen word is held in an output register until downstream takes it.
// Sources that are not granted see in_ready low and must wait.
module rr_mux_n
   import cgra_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   rr_mux_n_if.slave  bus
);

   localparam int SEL_W = $clog2(N_IN);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_grant_valid;
   logic [SEL_W-1:0] grant;
   logic             grant_valid;
   logic             load;
   logic             xfer;
   logic [N_IN-1:0]  ready_vec;
   logic [WIDTH-1:0] grant_data;
   logic [WIDTH-1:0] out_data_q;
   logic             out_valid_q;
   logic [SEL_W-1:0] out_src_q;

   rr_arbiter #(.N_IN(N_IN)) u_arb (
      .req         (bus.in_valid),
      .ptr         (ptr),
      .grant       (rr_grant),
      .grant_valid (rr_grant_valid)
   );

   // The output register can take a new word when empty or being drained this cycle.
   assign load = !out_valid_q || bus.out_ready;

   // Choose between the arbiter's pick and the explicit select; an out-of-range select grants nobody.
   always_comb begin
      if (bus.mode == MUX_MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_grant_valid;
      end else begin
         grant       = bus.sel;
         grant_valid = (int'(bus.sel) < N_IN);
      end
   end

   // Raise ready only on the granted channel and steer its data toward the register.
   always_comb begin
      ready_vec  = '0;
      grant_data = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (grant == SEL_W'(i)) begin
            ready_vec[i] = rst_n && load && grant_valid;
            grant_data   = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer         = |(ready_vec & bus.in_valid);
   assign bus.in_ready = ready_vec;

   // Output register and round-robin pointer; the pointer only advances on RR-mode transfers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr         <= '0;
      end else if (load) begin
         out_valid_q <= xfer;
         if (xfer) begin
            out_data_q <= grant_data;
            out_src_q  <= grant;
            if (bus.mode == MUX_MODE_RR) begin
               ptr <= SEL_W'(rr_next_ptr(int'(grant), N_IN));
            end
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_src   = out_src_q;

endmodule
